// File: rtl/ldst_control_unit.sv
// Moore control sequencer for Mini SRC fetch plus ld/ldi/st/nop/halt.
// Optional single-step gating is enabled by defining LDST_SINGLE_STEP_EN.
module ldst_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR_Data,
  input  logic        step,
  output logic        PC_out,
  output logic        PC_in,
  output logic        IncPC,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        Zlow_out,
  output logic        C_out,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_instruction_bits,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state, state_next;
  logic       illegal_set;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_nop, is_halt, is_mem;
  logic       go;
  logic       unused_bits;

  assign opcode  = IR_Data[31:27];
  assign is_ld   = (opcode == OP_LD);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_st   = (opcode == OP_ST);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign is_mem  = is_ld | is_ldi | is_st;

`ifdef LDST_SINGLE_STEP_EN
  assign go          = run & step;
  assign unused_bits = ^IR_Data[26:0];
`else
  assign go          = run;
  assign unused_bits = ^{IR_Data[26:0], step};
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next           = state;
    illegal_set          = 1'b0;
    PC_out               = 1'b0;
    PC_in                = 1'b0;
    IncPC                = 1'b0;
    MAR_in               = 1'b0;
    MDR_in               = 1'b0;
    MDR_out              = 1'b0;
    IR_in                = 1'b0;
    Y_in                 = 1'b0;
    Z_in                 = 1'b0;
    Zlow_out             = 1'b0;
    C_out                = 1'b0;
    Read                 = 1'b0;
    Write                = 1'b0;
    Gra                  = 1'b0;
    Grb                  = 1'b0;
    Rin                  = 1'b0;
    Rout                 = 1'b0;
    BAout                = 1'b0;
    alu_instruction_bits = '0;
    busy                 = 1'b0;
    halted               = 1'b0;
    instr_done           = 1'b0;

    case (state)
      S_IDLE: if (go) state_next = S_T0;
      S_T0: begin
        busy = 1'b1; PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        busy = 1'b1; Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        busy = 1'b1; MDR_out = 1'b1; IR_in = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1;
          state_next = S_T4;
        end else if (is_nop) begin
          instr_done = 1'b1;
          state_next = go ? S_T0 : S_IDLE;
        end else if (is_halt) begin
          instr_done = 1'b1;
          state_next = S_HALT;
        end else begin
          illegal_set = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_T4: begin
        busy = 1'b1; C_out = 1'b1; Z_in = 1'b1;
        alu_instruction_bits = ALU_ADD;
        state_next = S_T5;
      end
      S_T5: begin
        busy = 1'b1;
        if (is_ldi) begin
          Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          state_next = go ? S_T0 : S_IDLE;
        end else if (is_ld || is_st) begin
          Zlow_out = 1'b1; MAR_in = 1'b1;
          state_next = S_T6;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_T6: begin
        busy = 1'b1;
        state_next = S_T7;
        if (is_ld) begin
          Read = 1'b1; MDR_in = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_T7: begin
        busy = 1'b1;
        state_next = go ? S_T0 : S_IDLE;
        if (is_ld) begin
          MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else if (is_st) begin
          // Write sits alone in T7 so MDR was loaded a full cycle earlier
          Write = 1'b1; instr_done = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldst_control_unit.sv
// Scoreboard bench for ldst_control_unit: stimulus queues expected per-cycle
// output vectors, a monitor pops and compares them at each falling edge.
module tb_ldst_control_unit;

  logic        clk, clr, run, step;
  logic [31:0] IR_Data;
  logic PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in;
  logic Zlow_out, C_out, Read, Write, Gra, Grb, Rin, Rout, BAout;
  logic [4:0] alu_instruction_bits;
  logic busy, halted, illegal, instr_done;

  ldst_control_unit #(.ALU_ADD(5'b00011)) dut (
    .clk(clk), .clr(clr), .run(run), .IR_Data(IR_Data), .step(step),
    .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in),
    .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in), .Y_in(Y_in),
    .Z_in(Z_in), .Zlow_out(Zlow_out), .C_out(C_out), .Read(Read),
    .Write(Write), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .alu_instruction_bits(alu_instruction_bits),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LDST_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  localparam logic [26:0] M_PC_OUT  = 27'h1 << 26;
  localparam logic [26:0] M_PC_IN   = 27'h1 << 25;
  localparam logic [26:0] M_INCPC   = 27'h1 << 24;
  localparam logic [26:0] M_MAR_IN  = 27'h1 << 23;
  localparam logic [26:0] M_MDR_IN  = 27'h1 << 22;
  localparam logic [26:0] M_MDR_OUT = 27'h1 << 21;
  localparam logic [26:0] M_IR_IN   = 27'h1 << 20;
  localparam logic [26:0] M_Y_IN    = 27'h1 << 19;
  localparam logic [26:0] M_Z_IN    = 27'h1 << 18;
  localparam logic [26:0] M_ZLOW    = 27'h1 << 17;
  localparam logic [26:0] M_C_OUT   = 27'h1 << 16;
  localparam logic [26:0] M_READ    = 27'h1 << 15;
  localparam logic [26:0] M_WRITE   = 27'h1 << 14;
  localparam logic [26:0] M_GRA     = 27'h1 << 13;
  localparam logic [26:0] M_GRB     = 27'h1 << 12;
  localparam logic [26:0] M_RIN     = 27'h1 << 11;
  localparam logic [26:0] M_ROUT    = 27'h1 << 10;
  localparam logic [26:0] M_BAOUT   = 27'h1 << 9;
  localparam logic [26:0] M_ALUADD  = 27'h30;
  localparam logic [26:0] M_BUSY    = 27'h1 << 3;
  localparam logic [26:0] M_HALTED  = 27'h1 << 2;
  localparam logic [26:0] M_ILLEGAL = 27'h1 << 1;
  localparam logic [26:0] M_DONE    = 27'h1;

  localparam logic [26:0] V_IDLE  = '0;
  localparam logic [26:0] V_F0    = M_BUSY | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN;
  localparam logic [26:0] V_F1    = M_BUSY | M_ZLOW | M_PC_IN | M_READ | M_MDR_IN;
  localparam logic [26:0] V_F2    = M_BUSY | M_MDR_OUT | M_IR_IN;
  localparam logic [26:0] V_T3M   = M_BUSY | M_GRB | M_BAOUT | M_Y_IN;
  localparam logic [26:0] V_T3D   = M_BUSY | M_DONE;
  localparam logic [26:0] V_T3I   = M_BUSY;
  localparam logic [26:0] V_T4    = M_BUSY | M_C_OUT | M_ALUADD | M_Z_IN;
  localparam logic [26:0] V_T5M   = M_BUSY | M_ZLOW | M_MAR_IN;
  localparam logic [26:0] V_T5I   = M_BUSY | M_ZLOW | M_GRA | M_RIN | M_DONE;
  localparam logic [26:0] V_T6L   = M_BUSY | M_READ | M_MDR_IN;
  localparam logic [26:0] V_T6S   = M_BUSY | M_GRA | M_ROUT | M_MDR_IN;
  localparam logic [26:0] V_T7L   = M_BUSY | M_MDR_OUT | M_GRA | M_RIN | M_DONE;
  localparam logic [26:0] V_T7S   = M_BUSY | M_WRITE | M_DONE;
  localparam logic [26:0] V_HALT  = M_HALTED;
  localparam logic [26:0] V_HALTI = M_HALTED | M_ILLEGAL;

  localparam logic [31:0] I_ST   = 32'h12200090;
  localparam logic [31:0] I_LD   = 32'h000000F7;
  localparam logic [31:0] I_LDI  = 32'h09800025;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL  = 32'h18000000;

  logic [26:0] actual;
  assign actual = {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in,
                   Z_in, Zlow_out, C_out, Read, Write, Gra, Grb, Rin, Rout, BAout,
                   alu_instruction_bits, busy, halted, illegal, instr_done};

  logic [26:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;

  initial begin
    logic [26:0] e;
    string       n;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (actual !== e) begin
          errors++;
          $display("FAIL %s: got %07h expected %07h", n, actual, e);
        end
      end
    end
  end

  task automatic cyc(input logic [26:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string n);
    cyc(V_F0, {n, "_t0"});
    cyc(V_F1, {n, "_t1"});
    cyc(V_F2, {n, "_t2"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0; run = 1'b0; step = SS; IR_Data = '0;
    @(posedge clk); #1;
    cyc(V_IDLE, "rst0");
    run = 1'b1;
    cyc(V_IDLE, "rst_run_held");

    // st from IDLE, then ld and ldi back to back
    clr = 1'b1; IR_Data = I_ST;
    cyc(V_IDLE, "st_idle_go");
    fetch("st");
    cyc(V_T3M, "st_t3"); cyc(V_T4, "st_t4"); cyc(V_T5M, "st_t5");
    cyc(V_T6S, "st_t6"); cyc(V_T7S, "st_t7");
    IR_Data = I_LD;
    fetch("ld");
    cyc(V_T3M, "ld_t3"); cyc(V_T4, "ld_t4"); cyc(V_T5M, "ld_t5");
    cyc(V_T6L, "ld_t6"); cyc(V_T7L, "ld_t7");
    IR_Data = I_LDI;
    fetch("ldi");
    cyc(V_T3M, "ldi_t3"); cyc(V_T4, "ldi_t4"); cyc(V_T5I, "ldi_t5");
    IR_Data = I_NOP;
    fetch("nop");
    run = 1'b0;
    cyc(V_T3D, "nop_t3");
    cyc(V_IDLE, "nop_idle0"); cyc(V_IDLE, "nop_idle1");

    // run dropped at T2 of a st
    run = 1'b1; IR_Data = I_ST;
    cyc(V_IDLE, "st2_idle_go");
    cyc(V_F0, "st2_t0"); cyc(V_F1, "st2_t1");
    run = 1'b0;
    cyc(V_F2, "st2_t2");
    cyc(V_T3M, "st2_t3"); cyc(V_T4, "st2_t4"); cyc(V_T5M, "st2_t5");
    cyc(V_T6S, "st2_t6"); cyc(V_T7S, "st2_t7");
    cyc(V_IDLE, "st2_idle0"); cyc(V_IDLE, "st2_idle1");

    // run low mid-ldi, raised on the final step
    run = 1'b1; IR_Data = I_LDI;
    cyc(V_IDLE, "ldi2_idle_go");
    run = 1'b0;
    fetch("ldi2");
    cyc(V_T3M, "ldi2_t3"); cyc(V_T4, "ldi2_t4");
    run = 1'b1;
    cyc(V_T5I, "ldi2_t5");

    // async clr during T5 of a st
    IR_Data = I_ST;
    fetch("st3");
    cyc(V_T3M, "st3_t3"); cyc(V_T4, "st3_t4");
    exp_q.push_back(V_T5M); name_q.push_back("st3_t5");
    @(negedge clk); #1;
    clr = 1'b0;
    #1;
    exp_q.push_back(V_IDLE); name_q.push_back("clr_async");
    ->sample_ev;
    @(posedge clk); #1;
    cyc(V_IDLE, "clr_held");

    // halt
    clr = 1'b1; IR_Data = I_HALT;
    cyc(V_IDLE, "halt_idle_go");
    fetch("halt");
    cyc(V_T3D, "halt_t3");
    cyc(V_HALT, "halt0");
    run = 1'b0; cyc(V_HALT, "halt_run0");
    run = 1'b1; cyc(V_HALT, "halt_run1");

    // illegal opcode
    clr = 1'b0;
    cyc(V_IDLE, "rst2");
    clr = 1'b1; IR_Data = I_ILL;
    cyc(V_IDLE, "ill_idle_go");
    fetch("ill");
    cyc(V_T3I, "ill_t3");
    cyc(V_HALTI, "ill_halt0");
    run = 1'b0; cyc(V_HALTI, "ill_run0");
    run = 1'b1; cyc(V_HALTI, "ill_run1");
    cyc(V_HALTI, "ill_halt3");

`ifdef LDST_SINGLE_STEP_EN
    clr = 1'b0;
    cyc(V_IDLE, "ss_rst");
    clr = 1'b1; run = 1'b1; step = 1'b0; IR_Data = I_NOP;
    for (int i = 0; i < 10; i++) cyc(V_IDLE, "ss_hold");
    step = 1'b1;
    cyc(V_IDLE, "ss_go");
    step = 1'b0;
    fetch("ss");
    cyc(V_T3D, "ss_t3");
    cyc(V_IDLE, "ss_idle0"); cyc(V_IDLE, "ss_idle1");
`endif

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldst_control_unit.md
# ldst_control_unit

Hardwired Moore control sequencer that drives the Mini SRC datapath control inputs for instruction fetch and the memory-reference class (ld, ldi, st), plus nop and halt. It sits directly upstream of `datapath`: it consumes `IR_Data` and produces every per-step control strobe a bench would otherwise hand-drive. Any other opcode stops the machine with an error flag.

## Interface
Parameters:
- `ALU_ADD`, default 5'b00011, ALU select used for effective-address add.
- `OP_LD`, default 5'b00000; `OP_LDI`, default 5'b00001; `OP_ST`, default 5'b00010; `OP_NOP`, default 5'b11010; `OP_HALT`, default 5'b11011.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `run` in 1: level; permits starting or continuing instruction execution.
- `IR_Data` in 32: instruction register contents; opcode is `IR_Data[31:27]`.
- `step` in 1: single-step pulse, used only with `LDST_SINGLE_STEP_EN`.
- Outputs, 1 bit each: `PC_out`, `PC_in`, `IncPC`, `MAR_in`, `MDR_in`, `MDR_out`, `IR_in`, `Y_in`, `Z_in`, `Zlow_out`, `C_out`, `Read`, `Write`, `Gra`, `Grb`, `Rin`, `Rout`, `BAout`.
- `alu_instruction_bits` out 5: ALU operation select.
- `busy` out 1: set in any T-state.
- `halted` out 1: set in HALT.
- `illegal` out 1: sticky; set when HALT was entered on an unsupported opcode.
- `instr_done` out 1: one-cycle pulse on the final step of each completed instruction.

## Operation
- The state register is the only storage besides `illegal`. All control outputs are pure decodes of the current state plus `IR_Data[31:27]` (Moore), so there are no glitches across state boundaries.
- States: IDLE, T0–T7, HALT.
  - IDLE: moves to T0 when `run`=1.
  - T0: `PC_out`, `MAR_in`, `IncPC`, `Z_in`.
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
  - T3 (decode, using `IR_Data` loaded at the T2 edge):
    - ld/ldi/st: `Grb`, `BAout`, `Y_in`.
    - nop: no strobes, `instr_done`.
    - halt: no strobes, `instr_done`, next state HALT.
    - any other opcode: next state HALT, set `illegal`.
  - T4: `C_out`, `alu_instruction_bits`=`ALU_ADD`, `Z_in`. `alu_instruction_bits` is 0 in every other state.
  - T5:
    - ld/st: `Zlow_out`, `MAR_in`.
    - ldi: `Zlow_out`, `Gra`, `Rin`, `instr_done` (final step).
  - T6:
    - ld: `Read`, `MDR_in`.
    - st: `Gra`, `Rout`, `MDR_in`.
  - T7:
    - ld: `MDR_out`, `Gra`, `Rin`, `instr_done`.
    - st: `Write`, `instr_done`.
- After any final step, the next state is T0 if `run`=1, otherwise IDLE.
- `Write` and `MDR_in` are never asserted in the same state, so the store data is stable in MDR before the write.
- `Read` and `Write` are never asserted together.
- HALT: all strobes 0, `halted`=1. HALT is left only by `clr`.

## Timing
- Reset (`clr`=0, asynchronous): state IDLE, `illegal`=0, and every output 0, including `busy`, `halted`, `instr_done` and `alu_instruction_bits`.
- Reset released mid-instruction: state IDLE, and the partial instruction is abandoned. The datapath is not restored.
- Latency from IDLE with `run`=1: T0 begins on the next edge.
- Instruction lengths, in cycles from T0:
  - fetch: 3
  - nop: 4
  - ldi: 6
  - ld, st: 8
  - halt or illegal: 4, then HALT
- `run` falling mid-instruction: the current instruction completes, then the machine enters IDLE. `run` is sampled only in IDLE and on final steps.
- `run` rising in the same cycle as a final step: the machine continues to T0.

## Configuration
- `LDST_SINGLE_STEP_EN` defined:
  - IDLE and final steps advance to T0 only on a cycle where `run`=1 and `step`=1.
  - With `run`=1 and `step`=0, the machine waits in IDLE, with `busy`=0.
  - One `step` pulse executes exactly one instruction.
- Not defined: `step` is ignored, and execution is free-running under `run`.

## Test plan
- **st:** `IR_Data`=0x12200090 and `run`=1 from IDLE → T0–T7 strobes in order. `alu_instruction_bits`=5'b00011 only in T4. `Write`=1 only in T7. `instr_done` pulses at T7.
- **ld:** `IR_Data`=0x000000F7 → T6 shows `Read`+`MDR_in`, T7 shows `MDR_out`+`Gra`+`Rin`. Instruction takes 8 cycles.
- **ldi:** `IR_Data`=0x09800025 → T5 shows `Zlow_out`+`Gra`+`Rin` with `instr_done`, and the next state is T0. No `Read`/`Write` after T1.
- **halt and illegal:** `IR_Data`=0xD8000000 → HALT after T3, `halted`=1, `illegal`=0. After reset, `IR_Data`=0x18000000 → HALT with `illegal`=1. Toggling `run` does not leave HALT.
- **Mid-instruction events:**
  - `run` dropped at T2 of a st: the instruction finishes at T7, then IDLE with `busy`=0.
  - `clr` pulled low at T5: all outputs 0 immediately, state IDLE.
- **Single step** (with `LDST_SINGLE_STEP_EN`): `run`=1 with no `step` → IDLE holds for 10 cycles. One `step` pulse → exactly one instruction, then IDLE.
